// File: rtl/ex_div_shared.sv
// Iterative DIV/DIVU/REM/REMU unit shared by NUM_LANES EX lanes, serving the oldest pending lane first.
// A normal op is done DATA_WIDTH/BITS_PER_CYCLE+2 cycles after accept, a special-case op at the accept edge; stall_req holds the pipe meanwhile.
module ex_div_shared #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LANES      = 2,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            lane_req,
  input  logic [2*NUM_LANES-1:0]          lane_op,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_s1,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_s2,
  input  logic                            pipe_adv,
  input  logic                            flush,
  output logic [NUM_LANES-1:0]            lane_done,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_result,
  output logic                            stall_req
);
  localparam int W     = DATA_WIDTH;
  localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state;
  logic [LW-1:0] sel;
  logic          is_rem, q_neg, r_neg;
  logic [W-1:0]  quo, dvs, rem;
  logic [CW-1:0] cnt;

  logic [NUM_LANES-1:0] pending;
  logic [LW-1:0]        pick;
  logic [1:0]           pick_op;
  logic [W-1:0]         pick_s1, pick_s2;
  logic                 is_signed, div_zero, overflow;
  logic [W-1:0]         s1_abs, s2_abs, special;
  logic [W-1:0]         quo_nx, rem_nx;
  logic [W:0]           shifted, trial;
  logic [W-1:0]         q_fix, r_fix, fix_res;

  assign pending   = lane_req & ~lane_done;
  assign stall_req = |pending;

  // Descending scan so the lowest-index (oldest) pending lane wins.
  always_comb begin
    pick    = '0;
    pick_op = '0;
    pick_s1 = '0;
    pick_s2 = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick    = LW'(i);
        pick_op = lane_op[2*i +: 2];
        pick_s1 = lane_s1[i*W +: W];
        pick_s2 = lane_s2[i*W +: W];
      end
    end
  end

  assign is_signed = ~pick_op[0];
  assign s1_abs    = (is_signed && pick_s1[W-1]) ? -pick_s1 : pick_s1;
  assign s2_abs    = (is_signed && pick_s2[W-1]) ? -pick_s2 : pick_s2;
  assign div_zero  = (pick_s2 == '0);
  assign overflow  = is_signed && (pick_s1 == MIN_INT) && (pick_s2 == '1);
  assign special   = div_zero ? (pick_op[1] ? pick_s1 : '1)
                              : (pick_op[1] ? '0 : pick_s1);

  // Restoring steps; quo doubles as the dividend shift register.
  always_comb begin
    quo_nx  = quo;
    rem_nx  = rem;
    shifted = '0;
    trial   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      shifted = {rem_nx, quo_nx[W-1]};
      trial   = shifted - {1'b0, dvs};
      rem_nx  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      quo_nx  = {quo_nx[W-2:0], ~trial[W]};
    end
  end

  assign q_fix   = q_neg ? -quo : quo;
  assign r_fix   = r_neg ? -rem : rem;
  assign fix_res = is_rem ? r_fix : q_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      is_rem      <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quo         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      lane_done   <= '0;
      lane_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      lane_done <= '0;
    end else begin
      if (pipe_adv && !stall_req) lane_done <= '0;
      case (state)
        IDLE: begin
          if (stall_req) begin
            sel    <= pick;
            is_rem <= pick_op[1];
            if (div_zero || overflow) begin
              for (int i = 0; i < NUM_LANES; i++) begin
                if (pick == LW'(i)) begin
                  lane_result[i*W +: W] <= special;
                  lane_done[i]          <= 1'b1;
                end
              end
            end else begin
              state <= CALC;
              cnt   <= '0;
              quo   <= s1_abs;
              dvs   <= s2_abs;
              rem   <= '0;
              q_neg <= is_signed & (pick_s1[W-1] ^ pick_s2[W-1]);
              r_neg <= is_signed & pick_s1[W-1];
            end
          end
        end
        CALC: begin
          if (!lane_req[sel]) begin
            state <= IDLE;
          end else if (cnt == CW'(STEPS)) begin
            state <= FIX;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          state <= IDLE;
          if (lane_req[sel]) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (sel == LW'(i)) begin
                lane_result[i*W +: W] <= fix_res;
                lane_done[i]          <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_shared.sv
// Directed bench for ex_div_shared: a default 1-bit/cycle instance and a 2-bit/cycle instance.
module tb_ex_div_shared;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req, req2, done, done2;
  logic [3:0]  op, op2;
  logic [63:0] s1, s2, s1b, s2b, res, res2;
  logic        adv, adv2, fl, fl2, stall, stall2;
  int          n_chk = 0;
  int          n_pass = 0;

  ex_div_shared dut (
    .clk(clk), .rst_n(rst_n), .lane_req(req), .lane_op(op), .lane_s1(s1), .lane_s2(s2),
    .pipe_adv(adv), .flush(fl), .lane_done(done), .lane_result(res), .stall_req(stall));

  ex_div_shared #(.DATA_WIDTH(32), .NUM_LANES(2), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .lane_req(req2), .lane_op(op2), .lane_s1(s1b), .lane_s2(s2b),
    .pipe_adv(adv2), .flush(fl2), .lane_done(done2), .lane_result(res2), .stall_req(stall2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input bit u, input int lane, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (!u) begin
      req[lane] = 1'b1; op[lane*2 +: 2] = o; s1[lane*32 +: 32] = a; s2[lane*32 +: 32] = b;
    end else begin
      req2[lane] = 1'b1; op2[lane*2 +: 2] = o; s1b[lane*32 +: 32] = a; s2b[lane*32 +: 32] = b;
    end
  endtask

  // cyc = clock cycles after the accept edge at which lane_done is seen (1 = seen right after accept);
  // hi = cycles after accept with stall_req high before done.
  task automatic run(input bit u, input int lane, output int cyc, output int hi);
    logic [1:0] d;
    cyc = 0;
    hi  = 0;
    do begin
      @(negedge clk);
      cyc++;
      d = u ? done2 : done;
      if (!d[lane] && (u ? stall2 : stall)) hi++;
    end while (!d[lane] && cyc < 200);
  endtask

  task automatic release_lanes(input bit u);
    if (!u) begin req = '0; adv = 1'b1; end
    else begin req2 = '0; adv2 = 1'b1; end
    @(negedge clk);
    adv  = 1'b0;
    adv2 = 1'b0;
  endtask

  function automatic logic [31:0] rslt(input bit u, input int lane);
    return u ? res2[lane*32 +: 32] : res[lane*32 +: 32];
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      2'b00:   return ovf ? a : 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  initial begin
    int          cyc, hi, c0, c1, lane;
    logic        prev;
    logic [1:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0;
    req = '0; op = '0; s1 = '0; s2 = '0; adv = 1'b0; fl = 1'b0;
    req2 = '0; op2 = '0; s1b = '0; s2b = '0; adv2 = 1'b0; fl2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res_lo", res[31:0], 32'd0);
    chk("rst_res_hi", res[63:32], 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal path: done 34 edges after accept, stall high throughout.
    issue(0, 0, 2'b00, 32'd100, 32'd7);
    #1 chk("t1_stall_req_cycle", 32'(stall), 32'd1);
    run(0, 0, cyc, hi);
    chk("t1_div_lat", cyc, 32'd35);
    chk("t1_stall_cycles", hi, 32'd34);
    chk("t1_div_q", rslt(0, 0), 32'd14);
    repeat (2) @(negedge clk);
    chk("t1_hold_stall", 32'(stall), 32'd0);
    chk("t1_hold_done", 32'(done), 32'd1);
    release_lanes(0);
    chk("t1_adv_clear", 32'(done), 32'd0);
    issue(0, 0, 2'b10, 32'd100, 32'd7);
    run(0, 0, cyc, hi);
    chk("t1_rem_lat", cyc, 32'd35);
    chk("t1_rem_r", rslt(0, 0), 32'd2);
    release_lanes(0);

    // Divide by zero completes at the accept edge.
    issue(0, 0, 2'b01, 32'hFFFF_FFFF, 32'd0);
    run(0, 0, cyc, hi);
    chk("t2_divu0_lat", cyc, 32'd1);
    chk("t2_divu0_q", rslt(0, 0), 32'hFFFF_FFFF);
    release_lanes(0);
    issue(0, 0, 2'b11, 32'h0000_1234, 32'd0);
    run(0, 0, cyc, hi);
    chk("t2_remu0_lat", cyc, 32'd1);
    chk("t2_remu0_r", rslt(0, 0), 32'h0000_1234);
    release_lanes(0);

    // Signed overflow completes at the accept edge.
    issue(0, 0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(0, 0, cyc, hi);
    chk("t3_ovf_lat", cyc, 32'd1);
    chk("t3_ovf_q", rslt(0, 0), 32'h8000_0000);
    release_lanes(0);
    issue(0, 0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(0, 0, cyc, hi);
    chk("t3_ovf_r", rslt(0, 0), 32'd0);
    release_lanes(0);

    // Two lanes back to back; pipe_adv while still stalled must not clear lane 0.
    issue(0, 0, 2'b00, -32'd20, 32'd3);
    issue(0, 1, 2'b10, -32'd20, 32'd3);
    c0 = 0;
    c1 = 0;
    for (int c = 1; c <= 150; c++) begin
      prev = stall;
      @(negedge clk);
      if (c0 != 0 && c == c0 + 1) begin
        adv = 1'b0;
        chk("t4_adv_ignored", 32'(done[0]), 32'd1);
      end
      if (done[0] && c0 == 0) begin
        c0  = c;
        adv = 1'b1;
        chk("t4_q0", res[31:0], 32'hFFFF_FFFA);
      end
      if (done[1]) begin
        c1 = c;
        chk("t4_stall_fall", 32'(stall), 32'd0);
        chk("t4_stall_before", 32'(prev), 32'd1);
        break;
      end
    end
    adv = 1'b0;
    chk("t4_lat0", c0, 32'd35);
    chk("t4_lat1", c1, 32'd70);
    chk("t4_r1", res[63:32], 32'hFFFF_FFFE);
    chk("t4_q0_kept", res[31:0], 32'hFFFF_FFFA);
    release_lanes(0);

    // Flush in the 10th CALC cycle, then a clean re-issue.
    issue(0, 0, 2'b00, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    fl  = 1'b1;
    req = '0;
    @(negedge clk);
    fl = 1'b0;
    chk("t5_flush_stall", 32'(stall), 32'd0);
    chk("t5_flush_done", 32'(done), 32'd0);
    issue(0, 0, 2'b00, 32'd100, 32'd7);
    run(0, 0, cyc, hi);
    chk("t5_reissue_lat", cyc, 32'd35);
    chk("t5_reissue_q", rslt(0, 0), 32'd14);
    release_lanes(0);

    // Radix-4 instance against the reference model.
    for (int i = 0; i < 8; i++) begin
      lane = i % 2;
      o    = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) b = -b;
      if (b == 32'd0) b = 32'd1;
      issue(1, lane, o, a, b);
      run(1, lane, cyc, hi);
      chk("t6_lat", cyc, 32'd19);
      chk("t6_res", rslt(1, lane), ref_div(o, a, b));
      release_lanes(1);
      chk("t6_adv_clear", 32'(done2), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
